// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
// Contents: FSM state encoding, requester port IDs, default widths/limits.

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        IF_BUSY = 2'b01,
        DM_BUSY = 2'b10
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FAIR_LIMIT = 4;
    localparam int FAIR_W         = 4;

endpackage

// File: rtl/mem_arb_select.sv
// rtl/mem_arb_select.sv - grant selection with saturating DM-over-IF fairness counter
// Ports:
//   clk, reset         clock, async active-low reset
//   idle               arbiter is in IDLE and may grant this cycle
//   if_req, dm_req     raw requests
//   if_done, dm_done   completion pulses; a port in its done cycle is not a candidate
//   grant_valid        a grant is made this cycle
//   grant_port         PORT_IF or PORT_DM, meaningful when grant_valid=1

module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int FAIR_LIMIT = DEF_FAIR_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic if_req,
    input  logic dm_req,
    input  logic if_done,
    input  logic dm_done,
    output logic grant_valid,
    output logic grant_port
);

    localparam logic [FAIR_W-1:0] LIMIT = FAIR_W'(FAIR_LIMIT);

    logic [FAIR_W-1:0] fair_cnt;
    logic              if_cand;
    logic              dm_cand;

    // A requester whose done pulses this cycle is still holding its request
    // only because it has not yet seen the pulse; it must not be re-granted.
    assign if_cand = if_req & ~if_done;
    assign dm_cand = dm_req & ~dm_done;

    always_comb begin
        grant_valid = idle & (if_cand | dm_cand);
        grant_port  = PORT_IF;
        if (dm_cand && !(if_cand && fair_cnt == LIMIT)) begin
            grant_port = PORT_DM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fair_cnt <= '0;
        end else if (grant_valid) begin
            if (grant_port == PORT_IF || !if_req) begin
                fair_cnt <= '0;
            end else if (fair_cnt != LIMIT) begin
                fair_cnt <= fair_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter for a shared single-ported memory
// Ports:
//   clk, reset                         clock, async active-low reset
//   if_req/if_addr/if_rdata/if_done    instruction fetch read port
//   dm_req/dm_we/dm_addr/dm_wdata/
//   dm_rdata/dm_done                   load/store port
//   mem_req/mem_we/mem_addr/mem_wdata/
//   mem_rdata/mem_ready                registered memory-side handshake
//   pipe_stall                         freeze PC and IF/ID while a requester waits
//   busy                               a transaction is in flight

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FAIR_LIMIT = DEF_FAIR_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              pipe_stall,
    output logic              busy
);

    state_t state;
    state_t next_state;
    logic   grant_valid;
    logic   grant_port;
    logic   idle;

    assign idle = (state == IDLE);

    mem_arb_select #(
        .FAIR_LIMIT (FAIR_LIMIT)
    ) u_select (
        .clk         (clk),
        .reset       (reset),
        .idle        (idle),
        .if_req      (if_req),
        .dm_req      (dm_req),
        .if_done     (if_done),
        .dm_done     (dm_done),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = !idle;
        pipe_stall = (if_req & ~if_done) | (dm_req & ~dm_done);
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    next_state = (grant_port == PORT_DM) ? DM_BUSY : IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: mem_* load on the grant edge and hold until completion;
    // done pulses are single-cycle and default low every edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        mem_req <= 1'b1;
                        if (grant_port == PORT_DM) begin
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                IF_BUSY: begin
                    if (mem_ready) begin
                        if_rdata <= mem_rdata;
                        if_done  <= 1'b1;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                    end
                end
                DM_BUSY: begin
                    if (mem_ready) begin
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                        dm_done <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        pipe_stall;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .FAIR_LIMIT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_done    (if_done),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dm_done    (dm_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .pipe_stall (pipe_stall),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_dm_done", dm_done, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_stall", pipe_stall, 0);
        reset = 1'b1;
        step();

        // IF read, zero wait states
        if_req = 1'b1;
        if_addr = 32'h0040_0000;
        #1;
        chk("t1_stall_c0", pipe_stall, 1);
        chk("t1_memreq_c0", mem_req, 0);
        step();
        chk("t1_memreq_c1", mem_req, 1);
        chk("t1_addr_c1", mem_addr, 32'h0040_0000);
        chk("t1_we_c1", mem_we, 0);
        chk("t1_busy_c1", busy, 1);
        chk("t1_stall_c1", pipe_stall, 1);
        chk("t1_done_c1", if_done, 0);
        mem_ready = 1'b1;
        mem_rdata = 32'h8C22_0004;
        step();
        chk("t1_done_c2", if_done, 1);
        chk("t1_rdata_c2", if_rdata, 32'h8C22_0004);
        chk("t1_memreq_c2", mem_req, 0);
        chk("t1_busy_c2", busy, 0);
        chk("t1_stall_c2", pipe_stall, 0);
        exp_if_rdata = 32'h8C22_0004;
        if_req = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        step();
        chk("t1_done_c3", if_done, 0);
        chk("t1_rdata_c3", if_rdata, exp_if_rdata);
        chk("t1_memreq_c3", mem_req, 0);

        // DM store with three wait cycles
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 32'h1001_0008;
        dm_wdata = 32'hDEAD_BEEF;
        step();
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("t2_memreq_c%0d", c), mem_req, 1);
            chk($sformatf("t2_we_c%0d", c), mem_we, 1);
            chk($sformatf("t2_addr_c%0d", c), mem_addr, 32'h1001_0008);
            chk($sformatf("t2_wdata_c%0d", c), mem_wdata, 32'hDEAD_BEEF);
            chk($sformatf("t2_done_c%0d", c), dm_done, 0);
            if (c == 4) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h1234_5678;
            end
            step();
        end
        chk("t2_done_c5", dm_done, 1);
        chk("t2_rdata_c5", dm_rdata, 0);
        chk("t2_we_c5", mem_we, 0);
        chk("t2_memreq_c5", mem_req, 0);
        exp_dm_rdata = '0;
        dm_req = 1'b0;
        dm_we = 1'b0;
        mem_ready = 1'b0;
        step();
        chk("t2_done_c6", dm_done, 0);

        // simultaneous requests: DM first, IF granted in the dm_done cycle
        if_req = 1'b1;
        if_addr = 32'h0040_0004;
        dm_req = 1'b1;
        dm_addr = 32'h1001_0010;
        step();
        chk("t3_dm_first", mem_addr, 32'h1001_0010);
        chk("t3_we_c1", mem_we, 0);
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        step();
        chk("t3_dm_done", dm_done, 1);
        chk("t3_dm_rdata", dm_rdata, 32'h0BAD_F00D);
        exp_dm_rdata = 32'h0BAD_F00D;
        dm_req = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("t3_stall_c2", pipe_stall, 1);
        step();
        chk("t3_if_grant", mem_addr, 32'h0040_0004);
        chk("t3_memreq_c3", mem_req, 1);
        chk("t3_stall_c3", pipe_stall, 1);
        mem_ready = 1'b1;
        mem_rdata = 32'h2402_0001;
        step();
        chk("t3_if_done", if_done, 1);
        chk("t3_if_rdata", if_rdata, 32'h2402_0001);
        chk("t3_stall_c4", pipe_stall, 0);
        exp_if_rdata = 32'h2402_0001;
        if_req = 1'b0;
        mem_ready = 1'b0;
        step();

        // fairness: four DM grants with IF pending, then IF wins
        for (int k = 0; k < 4; k++) begin
            if_req = 1'b1;
            if_addr = 32'h0040_0100;
            dm_req = 1'b1;
            dm_we = 1'b0;
            dm_addr = 32'h1001_0020 + 32'(k * 4);
            step();
            chk($sformatf("t4_dm_grant%0d", k), mem_addr, 32'h1001_0020 + 32'(k * 4));
            if_req = 1'b0;
            mem_ready = 1'b1;
            mem_rdata = 32'hA000_0000 + 32'(k);
            step();
            chk($sformatf("t4_dm_done%0d", k), dm_done, 1);
            chk($sformatf("t4_dm_rdata%0d", k), dm_rdata, 32'hA000_0000 + 32'(k));
            exp_dm_rdata = 32'hA000_0000 + 32'(k);
            dm_req = 1'b0;
            mem_ready = 1'b0;
            step();
        end
        if_req = 1'b1;
        dm_req = 1'b1;
        dm_addr = 32'h1001_0040;
        step();
        chk("t4_if_wins_addr", mem_addr, 32'h0040_0100);
        chk("t4_if_wins_we", mem_we, 0);
        mem_ready = 1'b1;
        mem_rdata = 32'h3C01_1001;
        step();
        chk("t4_if_done", if_done, 1);
        chk("t4_if_rdata", if_rdata, 32'h3C01_1001);
        exp_if_rdata = 32'h3C01_1001;
        if_req = 1'b0;
        dm_req = 1'b0;
        mem_ready = 1'b0;
        step();
        if_req = 1'b1;
        dm_req = 1'b1;
        step();
        chk("t4_dm_after_clear", mem_addr, 32'h1001_0040);
        if_req = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        step();
        chk("t4_dm_done_last", dm_done, 1);
        chk("t4_dm_rdata_last", dm_rdata, 32'h5555_AAAA);
        exp_dm_rdata = 32'h5555_AAAA;
        dm_req = 1'b0;
        mem_ready = 1'b0;
        step();

        // mem_ready while idle has no effect
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        step();
        chk("t6_busy", busy, 0);
        chk("t6_memreq", mem_req, 0);
        chk("t6_if_done", if_done, 0);
        chk("t6_dm_done", dm_done, 0);
        chk("t6_if_rdata", if_rdata, exp_if_rdata);
        chk("t6_dm_rdata", dm_rdata, exp_dm_rdata);
        mem_ready = 1'b0;
        step();
        chk("t6_busy_2", busy, 0);
        chk("t6_dm_rdata_2", dm_rdata, exp_dm_rdata);

        // reset during DM_BUSY abandons the transaction
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 32'h1001_0080;
        dm_wdata = 32'hCAFE_F00D;
        step();
        chk("t5_memreq_before", mem_req, 1);
        chk("t5_busy_before", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_memreq_async", mem_req, 0);
        chk("t5_busy_async", busy, 0);
        chk("t5_we_async", mem_we, 0);
        dm_req = 1'b0;
        dm_we = 1'b0;
        step();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("t5_busy_after%0d", c), busy, 0);
            chk($sformatf("t5_dm_done_after%0d", c), dm_done, 0);
            chk($sformatf("t5_memreq_after%0d", c), mem_req, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
